// File: rtl/oppm_pkg.sv
// oppm_pkg: shared state type, default sizing and counter-width helper
// for the OPPM transmit path.
package oppm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GUARD
  } oppm_state_e;

  // Default geometry: 16 positions per symbol, 8 symbols per word.
  localparam int unsigned POS_CT          = 16;
  localparam int unsigned SYMS_PER_WORD   = 8;
  localparam int unsigned DEF_N           = $clog2(POS_CT);
  localparam int unsigned DEF_DATA_W      = SYMS_PER_WORD * DEF_N;
  localparam int unsigned DEF_L           = 8;
  localparam int unsigned DEF_PULSE_SLOTS = 4;
  localparam int unsigned DEF_GUARD_POS   = 2;

  // Counter width for a 0..range-1 counter, never narrower than one bit.
  function automatic int unsigned cw(input int unsigned range);
    return (range < 2) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/oppm_slot_timer.sv
// oppm_slot_timer: slot counter (0..L-1) nested under a position counter
// (0..2**N-1). Also reused by the scheduler to time the guard interval.
module oppm_slot_timer
  import oppm_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned L = DEF_L
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                run,
  output logic [cw(L)-1:0]    slot_ct,
  output logic [N-1:0]        pos_ct,
  output logic                pos_wrap,
  output logic                symbol_wrap
);

  localparam int unsigned     LW        = cw(L);
  localparam logic [LW-1:0]   SLOT_LAST = LW'(L - 1);
  localparam logic [N-1:0]    POS_LAST  = '1;

  logic [LW-1:0] r_slot;
  logic [N-1:0]  r_pos;

  // Wrap flags reflect the current count only; the caller qualifies them
  // with its own state so no path runs back through 'run'.
  assign pos_wrap    = (r_slot == SLOT_LAST);
  assign symbol_wrap = pos_wrap && (r_pos == POS_LAST);
  assign slot_ct     = r_slot;
  assign pos_ct      = r_pos;

  // Advance slot every running cycle; position steps (and wraps) on slot wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_slot <= '0;
      r_pos  <= '0;
    end else if (run) begin
      if (pos_wrap) begin
        r_slot <= '0;
        r_pos  <= r_pos + N'(1);
      end else begin
        r_slot <= r_slot + LW'(1);
      end
    end
  end

endmodule

// File: rtl/oppm_tx_scheduler.sv
// oppm_tx_scheduler: slices accepted words into N-bit OPPM symbols (MSB
// first) and drives a registered LED pulse in the matching position.
// Optional build macro OPPM_PREAMBLE_EN prepends a dual-pulse preamble
// symbol (pulses in position 0 and in the last position) to every word.
module oppm_tx_scheduler
  import oppm_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned N           = DEF_N,
  parameter int unsigned L           = DEF_L,
  parameter int unsigned PULSE_SLOTS = DEF_PULSE_SLOTS,
  parameter int unsigned GUARD_POS   = DEF_GUARD_POS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              pulse,
  output logic              busy,
  output logic              word_done
);

  localparam int unsigned SYMS = DATA_W / N;
`ifdef OPPM_PREAMBLE_EN
  localparam int unsigned SYMS_TOT = SYMS + 1;
`else
  localparam int unsigned SYMS_TOT = SYMS;
`endif
  localparam int unsigned   LW         = cw(L);
  localparam int unsigned   SW         = cw(SYMS_TOT);
  localparam logic [SW-1:0] SYM_LAST   = SW'(SYMS_TOT - 1);
  localparam logic [LW-1:0] PULSE_LAST = LW'(PULSE_SLOTS - 1);
  // Guard is timed on the position counter, so GUARD_POS must not exceed 2**N.
  localparam logic [N-1:0]  GUARD_LAST = N'((GUARD_POS == 0) ? 0 : GUARD_POS - 1);

  oppm_state_e       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [SW-1:0]     r_sym;
  logic              r_pulse;

  logic [LW-1:0]     w_slot;
  logic [N-1:0]      w_pos;
  logic [N-1:0]      w_symbol;
  logic              w_pos_wrap, w_sym_wrap;
  logic              w_kill, w_pulse_hit, w_data_sym;
  logic              w_pulse_nxt, w_tmr_clr, w_tmr_run;
  logic              w_load, w_shift, w_sym_clr, w_sym_inc;

  oppm_slot_timer #(
    .N (N),
    .L (L)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (w_tmr_clr),
    .run         (w_tmr_run),
    .slot_ct     (w_slot),
    .pos_ct      (w_pos),
    .pos_wrap    (w_pos_wrap),
    .symbol_wrap (w_sym_wrap)
  );

  assign w_symbol = r_shift[DATA_W-1 -: N];
  assign w_kill   = rst || abort;
  assign busy     = (r_state != IDLE);
  assign pulse    = r_pulse;

`ifdef OPPM_PREAMBLE_EN
  // Symbol index 0 is the preamble: both end positions pulse, data is untouched.
  assign w_pulse_hit = (w_slot <= PULSE_LAST) &&
                       ((r_sym == '0) ? ((w_pos == '0) || (w_pos == '1))
                                      : (w_pos == w_symbol));
  assign w_data_sym  = (r_sym != '0);
`else
  assign w_pulse_hit = (w_slot <= PULSE_LAST) && (w_pos == w_symbol);
  assign w_data_sym  = 1'b1;
`endif

  // Next state, handshake and datapath controls; rst/abort override all.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    word_done   = 1'b0;
    w_pulse_nxt = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_run   = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_sym_clr   = 1'b0;
    w_sym_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready  = 1'b1;
        w_tmr_clr = 1'b1;
        w_sym_clr = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_tmr_run   = 1'b1;
        w_pulse_nxt = w_pulse_hit;
        if (w_sym_wrap) begin
          w_shift = w_data_sym;
          if (r_sym == SYM_LAST) begin
            word_done   = 1'b1;
            w_sym_clr   = 1'b1;
            w_state_nxt = (GUARD_POS == 0) ? IDLE : GUARD;
          end else begin
            w_sym_inc = 1'b1;
          end
        end
      end
      GUARD: begin
        w_tmr_run = 1'b1;
        if (w_pos_wrap && (w_pos == GUARD_LAST)) begin
          w_tmr_clr   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_kill) begin
      in_ready    = 1'b0;
      word_done   = 1'b0;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_sym_inc   = 1'b0;
      w_sym_clr   = 1'b1;
      w_pulse_nxt = 1'b0;
      w_tmr_clr   = 1'b1;
      w_state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Word shift register, symbol index and registered LED pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_sym   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_pulse_nxt;
      if (w_load)       r_shift <= in_data;
      else if (w_shift) r_shift <= r_shift << N;
      if (w_sym_clr)      r_sym <= '0;
      else if (w_sym_inc) r_sym <= r_sym + SW'(1);
    end
  end

endmodule

// File: tb/tb_oppm_tx_scheduler.sv
// tb_oppm_tx_scheduler: two scheduler instances (PULSE_SLOTS<L with guard,
// and PULSE_SLOTS=L without guard) share one stimulus stream. A reference
// model turns each accepted word into absolute pulse/word_done cycles and a
// busy window; a negedge monitor pops those expectations and compares.
module tb_oppm_tx_scheduler;

  localparam int unsigned DW   = 8;
  localparam int unsigned N    = 2;
  localparam int unsigned L    = 4;
  localparam int unsigned P    = 1 << N;
  localparam int unsigned SYMS = DW / N;
`ifdef OPPM_PREAMBLE_EN
  localparam int unsigned SLOTS = SYMS + 1;
  localparam bit          PRE   = 1'b1;
`else
  localparam int unsigned SLOTS = SYMS;
  localparam bit          PRE   = 1'b0;
`endif
  localparam int unsigned WLEN = SLOTS * P * L;
  localparam int unsigned PS0 = 2, G0 = 1;
  localparam int unsigned PS1 = 4, G1 = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    in_ready, pulse, busy, word_done;

  oppm_tx_scheduler #(
    .DATA_W(DW), .N(N), .L(L), .PULSE_SLOTS(PS0), .GUARD_POS(G0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[0]), .abort(abort), .pulse(pulse[0]),
    .busy(busy[0]), .word_done(word_done[0])
  );

  oppm_tx_scheduler #(
    .DATA_W(DW), .N(N), .L(L), .PULSE_SLOTS(PS1), .GUARD_POS(G1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[1]), .abort(abort), .pulse(pulse[1]),
    .busy(busy[1]), .word_done(word_done[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk   = 1'b0;

  int exp_pulse[2][$];
  int exp_done[2][$];
  int busy_from[2];
  int busy_to[2];
  int n_acc[2];
  int ps_of[2] = '{PS0, PS1};
  int g_of[2]  = '{G0, G1};

  function automatic bit model_busy(int i, int c);
    return (c >= busy_from[i]) && (c <= busy_to[i]);
  endfunction

  function automatic void add_pulse(int i, int start);
    for (int j = 0; j < ps_of[i]; j++) exp_pulse[i].push_back(start + j);
  endfunction

  // Word accepted at edge e: SEND cycle k is absolute cycle e+k, the pin
  // follows one cycle later.
  function automatic void accept(int i, int e, logic [DW-1:0] d);
    int dv, sym, base, k;
    dv = int'(d);
    for (int s = 0; s < SLOTS; s++) begin
      base = e + 1 + s * P * L;
      if (PRE && s == 0) begin
        add_pulse(i, base);
        add_pulse(i, base + (P - 1) * L);
      end else begin
        k   = PRE ? s - 1 : s;
        sym = (dv >> (DW - N * (k + 1))) % P;
        add_pulse(i, base + sym * L);
      end
    end
    exp_done[i].push_back(e + WLEN - 1);
    busy_from[i] = e;
    busy_to[i]   = e + WLEN - 1 + g_of[i] * L;
    n_acc[i]++;
  endfunction

  // rst/abort sampled at edge e: nothing pulses from cycle e on, and the
  // word_done of cycle e-1 is suppressed.
  function automatic void flush(int i, int e);
    while (exp_pulse[i].size() > 0 && exp_pulse[i][$] >= e) void'(exp_pulse[i].pop_back());
    while (exp_done[i].size() > 0 && exp_done[i][$] >= e - 1) void'(exp_done[i].pop_back());
    if (busy_to[i] > e - 1) busy_to[i] = e - 1;
  endfunction

  task automatic tick();
    int e;
    e = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst || abort) flush(i, e);
      else if (in_valid && !model_busy(i, cyc)) accept(i, e, in_data);
    end
    @(posedge clk);
    cyc = e;
    #1;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while (n < 2000 && (model_busy(0, cyc) || model_busy(1, cyc) ||
           exp_pulse[0].size() > 0 || exp_pulse[1].size() > 0 ||
           exp_done[0].size() > 0 || exp_done[1].size() > 0)) begin
      tick();
      n++;
    end
    tick();
  endtask

  task automatic wait_acc(int target);
    int n;
    n = 0;
    while (n_acc[0] < target && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic check(string name, int inst, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cycle %0d: got %b expected %b", name, inst, cyc, act, exp);
    end
  endtask

  // Monitor: pop any expectation due this cycle and compare every output.
  initial begin
    logic ep, ed, eb, er;
    forever begin
      @(negedge clk);
      if (chk) begin
        for (int i = 0; i < 2; i++) begin
          ep = 1'b0;
          ed = 1'b0;
          if (exp_pulse[i].size() > 0 && exp_pulse[i][0] == cyc) begin
            ep = 1'b1;
            void'(exp_pulse[i].pop_front());
          end
          if (exp_done[i].size() > 0 && exp_done[i][0] == cyc) begin
            ed = 1'b1;
            void'(exp_done[i].pop_front());
          end
          eb = model_busy(i, cyc);
          er = !eb && !rst && !abort;
          check("pulse", i, pulse[i], ep);
          check("word_done", i, word_done[i], ed);
          check("busy", i, busy[i], eb);
          check("in_ready", i, in_ready[i], er);
        end
      end
    end
  end

  initial begin
    int base;
    for (int i = 0; i < 2; i++) begin
      busy_from[i] = 0;
      busy_to[i]   = -1;
      n_acc[i]     = 0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk = 1'b1;

    // E4 one cycle after reset; in_data changes mid-word must be ignored.
    tick();
    in_valid = 1'b1;
    in_data  = 8'hE4;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    in_data = 8'h00;
    idle_wait();

    // Held valid: 00 then FF, second accepted only once idle again.
    in_valid = 1'b1;
    in_data  = 8'h00;
    base     = n_acc[0];
    wait_acc(base + 1);
    in_data = 8'hFF;
    wait_acc(base + 2);
    in_valid = 1'b0;
    idle_wait();

    // Symbol 3 then 0: continuous pulse across the boundary when PULSE_SLOTS=L.
    in_valid = 1'b1;
    in_data  = 8'hCC;
    tick();
    in_valid = 1'b0;
    idle_wait();

    // Abort during symbol 1, then 1B transmits from symbol 0.
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    in_valid = 1'b1;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h1B;
    tick();
    in_valid = 1'b0;
    idle_wait();

    // Reset while instance 0 is in GUARD.
    in_valid = 1'b1;
    in_data  = 8'hE4;
    tick();
    in_valid = 1'b0;
    repeat (65) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Randomized traffic with occasional abort and reset.
    for (int k = 0; k < 3000; k++) begin
      in_data  = DW'($urandom);
      in_valid = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 99) == 0);
      rst      = ($urandom_range(0, 399) == 0);
      tick();
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    rst      = 1'b0;
    idle_wait();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
